fu_result_buffer: RTL and testbench



---
 rtl/fu_result_buffer.sv | 137 +++++++++++++
 tb/tb_fu_result_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_result_buffer.sv
// Buffers functional-unit results in a circular FIFO and broadcasts the oldest ones on registered CDB lanes.
// Optional FU_RESULT_BYPASS_EN: accepted results skip an empty FIFO and load the CDB registers directly.
package fu_result_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  dest_reg_idx;
    logic [31:0] value;
  } FU_RS_PACKET;
endpackage

module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int NUM_FU    = 2,
  parameter int DEPTH     = 4,
  parameter int CDB_WIDTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  FU_RS_PACKET                  fu_result [NUM_FU],
  output logic [NUM_FU-1:0]            fu_stall,
  output FU_RS_PACKET                  cdb_packet [CDB_WIDTH],
  output logic [CDB_WIDTH-1:0]         cdb_valid,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  FU_RS_PACKET          r_mem [DEPTH];
  FU_RS_PACKET          r_cdb_pkt [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] r_cdb_vld;

  logic                 w_bypass;
  logic [NUM_FU-1:0]    w_wr_en;
  logic [PW-1:0]        w_wr_idx [NUM_FU];
  logic [NUM_FU-1:0]    w_to_cdb;
  logic [LW-1:0]        w_byp_lane [NUM_FU];
  int                   w_n_acc;
  int                   w_n_push;
  int                   w_pop;

  // Accepted inputs take consecutive slots in FU index order; free space ignores this cycle's drain.
  always_comb begin
    int nv;
    int slot;
    nv       = 0;
    slot     = 0;
    w_n_acc  = 0;
    w_bypass = 1'b0;
`ifdef FU_RESULT_BYPASS_EN
    w_bypass = (r_count == '0) && !squash;
`endif
    for (int i = 0; i < NUM_FU; i++) begin
      fu_stall[i]   = 1'b0;
      w_wr_en[i]    = 1'b0;
      w_wr_idx[i]   = '0;
      w_to_cdb[i]   = 1'b0;
      w_byp_lane[i] = '0;
      if (fu_result[i].valid && !squash) begin
        nv = nv + 1;
        if (nv <= DEPTH - int'(r_count)) begin
          slot    = nv - 1;
          w_n_acc = nv;
          if (w_bypass && slot < CDB_WIDTH) begin
            w_to_cdb[i]   = 1'b1;
            w_byp_lane[i] = LW'(slot);
          end else begin
            w_wr_en[i]  = 1'b1;
            w_wr_idx[i] = r_tail + PW'(w_bypass ? slot - CDB_WIDTH : slot);
          end
        end else begin
          fu_stall[i] = 1'b1;
        end
      end
    end
    if (w_bypass) begin
      w_n_push = (w_n_acc > CDB_WIDTH) ? w_n_acc - CDB_WIDTH : 0;
    end else begin
      w_n_push = w_n_acc;
    end
    w_pop = (int'(r_count) < CDB_WIDTH) ? int'(r_count) : CDB_WIDTH;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_wr_en[i]) begin
        r_mem[w_wr_idx[i]] <= fu_result[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_cdb_vld <= '0;
      for (int j = 0; j < CDB_WIDTH; j++) begin
        r_cdb_pkt[j] <= '0;
      end
    end else if (squash) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_cdb_vld <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_n_push);
      r_count <= CW'(int'(r_count) + w_n_push - w_pop);
      for (int j = 0; j < CDB_WIDTH; j++) begin
        if (j < w_pop) begin
          r_cdb_pkt[j] <= r_mem[r_head + PW'(j)];
          r_cdb_vld[j] <= 1'b1;
        end else begin
          r_cdb_vld[j] <= 1'b0;
        end
      end
      // Bypass only fires with an empty FIFO, so it never collides with a drain lane.
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_to_cdb[i]) begin
          r_cdb_pkt[w_byp_lane[i]] <= fu_result[i];
          r_cdb_vld[w_byp_lane[i]] <= 1'b1;
        end
      end
    end
  end

  assign cdb_packet = r_cdb_pkt;
  assign cdb_valid  = r_cdb_vld;
  assign occupancy  = r_count;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: directed vector table, hand sequences and random traffic against a queue model.
`timescale 1ns/1ps
module tb_fu_result_buffer;
  import fu_result_buffer_pkg::*;

  localparam int NF = 3;
  localparam int DP = 4;
  localparam int CW = 2;
`ifdef FU_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  FU_RS_PACKET   fu_result [NF];
  logic [NF-1:0] fu_stall;
  FU_RS_PACKET   cdb_packet [CW];
  logic [CW-1:0] cdb_valid;
  logic [2:0]    occupancy;

  fu_result_buffer #(.NUM_FU(NF), .DEPTH(DP), .CDB_WIDTH(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_result  (fu_result),
    .fu_stall   (fu_stall),
    .cdb_packet (cdb_packet),
    .cdb_valid  (cdb_valid),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NF-1:0] vld;
    logic [4:0]    d0, d1, d2;
    logic          sq;
    logic [NF-1:0] stall;
    logic [CW-1:0] cvld;
    logic [4:0]    c0, c1;
    logic [2:0]    occ;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  FU_RS_PACKET   mq[$];
  logic [NF-1:0] g_exp_stall;
  logic [NF-1:0] g_stall;
  vec_t          tbl[$];
  FU_RS_PACKET   cur [NF];
  logic [NF-1:0] hold;
  int            next_id;
  int            seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NF-1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [4:0] d2, input logic sq);
    logic [4:0] d [NF];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < NF; i++) begin
      fu_result[i].valid        = v[i];
      fu_result[i].dest_reg_idx = d[i];
      fu_result[i].value        = {19'h0, 8'(i + 1), d[i]};
    end
    squash = sq;
  endtask

  // Queue model: stall/accept from current fill, then pop oldest (or bypass) and append accepted.
  task automatic cycle();
    int            sz;
    int            fr;
    int            nv;
    logic          sq;
    FU_RS_PACKET   acc[$];
    FU_RS_PACKET   ep [CW];
    logic [CW-1:0] ev;
    sz = mq.size();
    fr = DP - sz;
    nv = 0;
    sq = squash;
    g_exp_stall = '0;
    #3;
    for (int i = 0; i < NF; i++) begin
      if (fu_result[i].valid && !sq) begin
        nv++;
        if (nv <= fr) acc.push_back(fu_result[i]);
        else g_exp_stall[i] = 1'b1;
      end
    end
    g_stall = fu_stall;
    check("fu_stall", fu_stall, g_exp_stall);
    @(posedge clock);
    #1;
    ev = '0;
    for (int l = 0; l < CW; l++) ep[l] = '0;
    if (sq) begin
      mq.delete();
    end else begin
      for (int l = 0; l < CW; l++) begin
        if (BYP && sz == 0) begin
          if (acc.size() > 0) begin ep[l] = acc.pop_front(); ev[l] = 1'b1; end
        end else if (mq.size() > 0) begin
          ep[l] = mq.pop_front(); ev[l] = 1'b1;
        end
      end
      while (acc.size() > 0) mq.push_back(acc.pop_front());
    end
    check("cdb_valid", cdb_valid, ev);
    check("occupancy", occupancy, mq.size());
    for (int l = 0; l < CW; l++)
      if (ev[l]) check($sformatf("cdb_packet%0d", l), cdb_packet[l], ep[l]);
  endtask

  task automatic reset_mid();
    drive('0, 0, 0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_occupancy", occupancy, 0);
    check("arst_cdb_valid", cdb_valid, 0);
    check("arst_cdb_packet0", cdb_packet[0], 0);
    check("arst_fu_stall", fu_stall, 0);
    #1;
    reset = 1'b0;
    mq.delete();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] vld, input logic [4:0] d0, input logic [4:0] d1,
                              input logic [4:0] d2, input logic sq, input logic [2:0] st,
                              input logic [1:0] cv, input logic [4:0] c0, input logic [4:0] c1,
                              input logic [2:0] oc);
    vec_t r;
    r.vld = vld; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.sq = sq;
    r.stall = st; r.cvld = cv; r.c0 = c0; r.c1 = c1; r.occ = oc;
    return r;
  endfunction

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    for (int i = 0; i < NF; i++) fu_result[i] = '0;
    #2;
    check("rst_occupancy", occupancy, 0);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_packet0", cdb_packet[0], 0);
    check("rst_fu_stall", fu_stall, 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;

`ifdef FU_RESULT_BYPASS_EN
    tbl.push_back(mk(3'b001,  5, 0, 0, 0, 3'b000, 2'b01,  5,  0, 0));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b00,  0,  0, 0));
    tbl.push_back(mk(3'b011,  3, 7, 0, 0, 3'b000, 2'b11,  3,  7, 0));
    tbl.push_back(mk(3'b111, 10,11,12, 0, 3'b000, 2'b11, 10, 11, 1));
    tbl.push_back(mk(3'b011, 13,14, 0, 0, 3'b000, 2'b01, 12,  0, 2));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b11, 13, 14, 0));
    tbl.push_back(mk(3'b111, 20,21,22, 1, 3'b000, 2'b00,  0,  0, 0));
`else
    tbl.push_back(mk(3'b001,  5, 0, 0, 0, 3'b000, 2'b00,  0,  0, 1));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b01,  5,  0, 0));
    tbl.push_back(mk(3'b011,  3, 7, 0, 0, 3'b000, 2'b00,  0,  0, 2));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b11,  3,  7, 0));
    tbl.push_back(mk(3'b111, 10,11,12, 0, 3'b000, 2'b00,  0,  0, 3));
    tbl.push_back(mk(3'b011, 13,14, 0, 0, 3'b010, 2'b11, 10, 11, 2));
    tbl.push_back(mk(3'b010,  0,14, 0, 0, 3'b000, 2'b11, 12, 13, 1));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b01, 14,  0, 0));
    tbl.push_back(mk(3'b111, 20,21,22, 0, 3'b000, 2'b00,  0,  0, 3));
    tbl.push_back(mk(3'b011, 23,24, 0, 1, 3'b000, 2'b00,  0,  0, 0));
    tbl.push_back(mk(3'b000,  0, 0, 0, 0, 3'b000, 2'b00,  0,  0, 0));
`endif
    foreach (tbl[k]) begin
      drive(tbl[k].vld, tbl[k].d0, tbl[k].d1, tbl[k].d2, tbl[k].sq);
      cycle();
      check($sformatf("tbl%0d_stall", k), g_stall, tbl[k].stall);
      check($sformatf("tbl%0d_cdb_valid", k), cdb_valid, tbl[k].cvld);
      check($sformatf("tbl%0d_occupancy", k), occupancy, tbl[k].occ);
      if (tbl[k].cvld[0]) check($sformatf("tbl%0d_lane0_dest", k), cdb_packet[0].dest_reg_idx, tbl[k].c0);
      if (tbl[k].cvld[1]) check($sformatf("tbl%0d_lane1_dest", k), cdb_packet[1].dest_reg_idx, tbl[k].c1);
    end

    // Asynchronous reset with entries held, then with lanes broadcasting.
    drive(3'b111, 1, 2, 3, 1'b0);
    cycle();
    reset_mid();
    drive(3'b001, 9, 0, 0, 1'b0);
    cycle();
    drive('0, 0, 0, 0, 1'b0);
    cycle();
    cycle();
    drive(3'b111, 4, 5, 6, 1'b0);
    cycle();
    drive(3'b111, 7, 8, 9, 1'b0);
    cycle();
    reset_mid();
    drive('0, 0, 0, 0, 1'b0);
    repeat (3) cycle();

    // Ten-result stream through the ring with stalls and holds.
    hold    = '0;
    next_id = 100;
    seen    = 0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!hold[i]) begin
          if (next_id < 110) begin
            cur[i].valid        = 1'b1;
            cur[i].dest_reg_idx = 5'(next_id);
            cur[i].value        = 32'(next_id);
            next_id++;
          end else begin
            cur[i] = '0;
          end
        end
      end
      for (int i = 0; i < NF; i++) fu_result[i] = cur[i];
      squash = 1'b0;
      cycle();
      for (int l = 0; l < CW; l++) if (cdb_valid[l]) seen++;
      check("wrap_occupancy_le_depth", 64'(occupancy <= 3'd4), 1);
      hold = g_exp_stall;
    end
    check("wrap_broadcast_count", seen, 10);

    // Random traffic with held packets on stall and occasional squash.
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!hold[i]) begin
          cur[i].valid        = ($urandom_range(0, 99) < 60);
          cur[i].dest_reg_idx = 5'($urandom);
          cur[i].value        = $urandom;
        end
      end
      for (int i = 0; i < NF; i++) fu_result[i] = cur[i];
      squash = ($urandom_range(0, 39) == 0);
      cycle();
      hold = g_exp_stall;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
